fpnew_slice_issue_arbiter: RTL and testbench

- Shares one in-order FP format-slice datapath (ADDMUL/NONCOMP opgroup slice) between NumReq requesters, e.g. integer core plus accelerator ports.
- Round-robin arbitration on the issue side.
- An internal ID FIFO records the requester of every accepted operation, so each slice result is routed back to its owner in issue order.
- Sits between requester ports and the slice valid/ready handshakes.

---
 rtl/fpnew_slice_issue_arbiter.sv | 141 ++++++++++++++
 tb/tb_fpnew_slice_issue_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_slice_issue_arbiter.sv
// rtl/fpnew_slice_issue_arbiter.sv - round-robin issue arbiter sharing one FP slice between requesters
// Issued owner IDs are queued so in-order slice results are steered back to their requester.
module fpnew_slice_issue_arbiter #(
    parameter int unsigned NumReq       = 2,
    parameter int unsigned PayloadWidth = 64,
    parameter int unsigned ResultWidth  = 37,
    parameter int unsigned MaxInflight  = 4,
    localparam int unsigned IdWidth     = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned CntWidth    = $clog2(MaxInflight + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq*PayloadWidth-1:0]   req_payload_i,
    output logic                             slc_valid_o,
    input  logic                             slc_ready_i,
    output logic [PayloadWidth-1:0]          slc_payload_o,
    input  logic                             slc_out_valid_i,
    output logic                             slc_out_ready_o,
    input  logic [ResultWidth-1:0]           slc_result_i,
    output logic [NumReq-1:0]                rsp_valid_o,
    input  logic [NumReq-1:0]                rsp_ready_i,
    output logic [ResultWidth-1:0]           rsp_result_o,
    output logic [IdWidth-1:0]               rsp_id_o,
    input  logic                             flush_i,
    output logic                             slc_flush_o,
    output logic [CntWidth-1:0]              inflight_o,
    output logic                             busy_o
);

    localparam int unsigned PtrWidth = (MaxInflight > 1) ? $clog2(MaxInflight) : 1;

    logic [IdWidth-1:0]  r_rr_ptr;
    logic                r_lock;
    logic [IdWidth-1:0]  r_lock_id;
    logic [IdWidth-1:0]  r_fifo [MaxInflight];
    logic [PtrWidth-1:0] r_wptr;
    logic [PtrWidth-1:0] r_rptr;
    logic [CntWidth-1:0] r_count;

    logic [2*NumReq-1:0] w_valid2;
    logic [NumReq-1:0]   w_rot;
    logic [IdWidth-1:0]  w_off;
    logic [IdWidth:0]    w_sum;
    logic [IdWidth-1:0]  w_grant;
    logic [IdWidth-1:0]  w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_can_issue;
    logic                w_issue;
    logic                w_pop;
    logic                w_head_ready;
    logic                w_rsp_ok;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CntWidth'(MaxInflight));
    // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign w_can_issue = rst_ni & ~w_full & ~flush_i;
    assign slc_valid_o = w_can_issue & (|req_valid_i);
    assign w_issue     = slc_valid_o & slc_ready_i;
    assign w_head      = w_empty ? '0 : r_fifo[r_rptr];
    assign w_rsp_ok    = slc_out_valid_i & ~w_empty & ~flush_i;
    assign w_pop       = slc_out_valid_i & slc_out_ready_o;

    // Rotate the valid vector so the first set bit is the offset from the RR pointer.
    always_comb begin
        w_valid2 = {req_valid_i, req_valid_i};
        w_rot    = NumReq'(w_valid2 >> r_rr_ptr);
        w_off    = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = IdWidth'(i);
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= (IdWidth + 1)'(NumReq)) w_sum = w_sum - (IdWidth + 1)'(NumReq);
        w_grant = r_lock ? r_lock_id : w_sum[IdWidth-1:0];
    end

    always_comb begin
        slc_payload_o = '0;
        req_ready_o   = '0;
        rsp_valid_o   = '0;
        w_head_ready  = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (w_grant == IdWidth'(i)) begin
                slc_payload_o  = rst_ni ? req_payload_i[i*PayloadWidth +: PayloadWidth] : '0;
                req_ready_o[i] = w_issue;
            end
            if (w_head == IdWidth'(i)) begin
                w_head_ready   = rsp_ready_i[i];
                rsp_valid_o[i] = w_rsp_ok;
            end
        end
    end

    assign slc_out_ready_o = w_head_ready & ~w_empty & ~flush_i;
    assign rsp_result_o    = rst_ni ? slc_result_i : '0;
    assign rsp_id_o        = w_head;
    assign slc_flush_o     = flush_i & rst_ni;
    assign inflight_o      = r_count;
    assign busy_o          = ~w_empty | slc_valid_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            for (int i = 0; i < MaxInflight; i++) r_fifo[i] <= '0;
        end else if (flush_i) begin
            r_lock  <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_issue) begin
                r_fifo[r_wptr] <= w_grant;
                r_wptr   <= (r_wptr == PtrWidth'(MaxInflight - 1)) ? '0 : r_wptr + 1'b1;
                r_rr_ptr <= (w_grant == IdWidth'(NumReq - 1)) ? '0 : w_grant + 1'b1;
                r_lock   <= 1'b0;
            end else if (slc_valid_o) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_grant;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PtrWidth'(MaxInflight - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_result_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(slc_out_valid_i && w_empty));

endmodule

// File: tb/tb_fpnew_slice_issue_arbiter.sv
// tb/tb_fpnew_slice_issue_arbiter.sv - randomized scoreboard bench for fpnew_slice_issue_arbiter
module tb_fpnew_slice_issue_arbiter;
    localparam int N  = 2;
    localparam int P  = 64;
    localparam int R  = 37;
    localparam int M  = 4;
    localparam int IW = 1;
    localparam int CW = 3;
    localparam logic [R-1:0] K = 37'h0A5A5A5A5A;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready_o;
    logic [N*P-1:0]  req_payload = '0;
    logic            slc_valid_o;
    logic            slc_ready = 1'b0;
    logic [P-1:0]    slc_payload_o;
    logic            slc_out_valid = 1'b0;
    logic            slc_out_ready_o;
    logic [R-1:0]    slc_result = '0;
    logic [N-1:0]    rsp_valid_o;
    logic [N-1:0]    rsp_ready = '0;
    logic [R-1:0]    rsp_result_o;
    logic [IW-1:0]   rsp_id_o;
    logic            flush = 1'b0;
    logic            slc_flush_o;
    logic [CW-1:0]   inflight_o;
    logic            busy_o;

    fpnew_slice_issue_arbiter #(.NumReq(N), .PayloadWidth(P), .ResultWidth(R), .MaxInflight(M)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_payload_i(req_payload),
        .slc_valid_o(slc_valid_o), .slc_ready_i(slc_ready), .slc_payload_o(slc_payload_o),
        .slc_out_valid_i(slc_out_valid), .slc_out_ready_o(slc_out_ready_o), .slc_result_i(slc_result),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result_o), .rsp_id_o(rsp_id_o),
        .flush_i(flush), .slc_flush_o(slc_flush_o), .inflight_o(inflight_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [P-1:0] p; int due; } slc_t;
    typedef struct { int id; logic [P-1:0] p; } sb_t;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ref_ptr = 0;
    int ref_lock = -1;
    int ref_fifo[$];
    slc_t sq[$];
    sb_t sb[$];
    bit pend[N];
    logic [P-1:0] pay[N];
    int p_req, p_srdy, p_rrdy, p_flush, lat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            if (!pend[r] && $urandom_range(99) < p_req) begin
                pend[r] = 1'b1;
                pay[r]  = {$urandom, $urandom};
            end
            req_valid[r] = pend[r];
            req_payload[r*P +: P] = pay[r];
            rsp_ready[r] = ($urandom_range(99) < p_rrdy);
        end
        slc_ready = ($urandom_range(99) < p_srdy);
        flush     = ($urandom_range(99) < p_flush);
        slc_out_valid = (sq.size() > 0) && (sq[0].due <= cyc);
        if (slc_out_valid) slc_result = sq[0].p[R-1:0] ^ K;
        else               slc_result = R'({$urandom, $urandom});
    endtask

    // Reference: expected issue/return behaviour from the arbitration rules, then advance the model.
    task automatic check_and_step();
        int  n, g, h;
        bit  can, any, ev, ne, ordy;
        slc_t s;
        sb_t  e;
        n   = ref_fifo.size();
        can = (n < M) && !flush;
        any = |req_valid;
        g   = 0;
        if (ref_lock >= 0) g = ref_lock;
        else begin
            for (int k = N - 1; k >= 0; k--) if (req_valid[(ref_ptr + k) % N]) g = (ref_ptr + k) % N;
        end
        ev = can && any;
        chk("slc_valid", 64'(slc_valid_o), 64'(ev));
        if (ev) chk("slc_payload", slc_payload_o, pay[g]);
        chk("req_ready", 64'(req_ready_o), (ev && slc_ready) ? 64'(1 << g) : 64'(0));
        chk("inflight", 64'(inflight_o), 64'(n));
        chk("busy", 64'(busy_o), 64'((n > 0) || ev));
        chk("slc_flush", 64'(slc_flush_o), 64'(flush));
        ne   = n > 0;
        h    = ne ? ref_fifo[0] : 0;
        ordy = ne && rsp_ready[h] && !flush;
        chk("out_ready", 64'(slc_out_ready_o), 64'(ordy));
        chk("rsp_valid", 64'(rsp_valid_o), (ne && slc_out_valid && !flush) ? 64'(1 << h) : 64'(0));
        if (ne) chk("rsp_id", 64'(rsp_id_o), 64'(h));
        if (flush) begin
            ref_fifo.delete();
            sq.delete();
            ref_lock = -1;
        end else begin
            if (ne && slc_out_valid && ordy) begin
                void'(ref_fifo.pop_front());
                void'(sq.pop_front());
            end
            if (ev && slc_ready) begin
                ref_fifo.push_back(g);
                s.p = pay[g]; s.due = cyc + lat; sq.push_back(s);
                e.id = g; e.p = pay[g]; sb.push_back(e);
                pend[g]  = 1'b0;
                ref_ptr  = (g + 1) % N;
                ref_lock = -1;
            end else if (ev) begin
                ref_lock = g;
            end
        end
    endtask

    task automatic run_phase(input int ncyc, input int a, input int b, input int c, input int d, input int l);
        p_req = a; p_srdy = b; p_rrdy = c; p_flush = d; lat = l;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            drive();
            @(negedge clk);
            check_and_step();
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_slc_valid", 64'(slc_valid_o), 64'(0));
        chk("rst_req_ready", 64'(req_ready_o), 64'(0));
        chk("rst_slc_payload", slc_payload_o, 64'(0));
        chk("rst_out_ready", 64'(slc_out_ready_o), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("rst_rsp_result", 64'(rsp_result_o), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id_o), 64'(0));
        chk("rst_slc_flush", 64'(slc_flush_o), 64'(0));
        chk("rst_inflight", 64'(inflight_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs();
        ref_fifo.delete();
        sq.delete();
        ref_ptr  = 0;
        ref_lock = -1;
        for (int r = 0; r < N; r++) pend[r] = 1'b0;
        req_valid = '0; flush = 1'b0; slc_out_valid = 1'b0; slc_ready = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a response handshake.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst_ni || flush) begin
                sb.delete();
            end else if (slc_out_valid && slc_out_ready_o) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got response id %0d expected none", rsp_id_o);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_owner", 64'(rsp_id_o), 64'(e.id));
                    chk("rsp_result", 64'(rsp_result_o), 64'(e.p[R-1:0] ^ K));
                    chk("rsp_onehot", 64'(rsp_valid_o), 64'(1 << e.id));
                end
            end
        end
    end

    initial begin
        for (int r = 0; r < N; r++) begin pend[r] = 1'b0; pay[r] = '0; end
        req_valid   = '1;
        req_payload = {N{64'hDEAD_BEEF_CAFE_F00D}};
        flush       = 1'b1;
        #2;
        check_reset_outputs();
        req_valid = '0; flush = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        run_phase(40, 100, 100, 100, 0, 2);
        run_phase(200, 60, 30, 100, 0, 1);
        run_phase(150, 80, 100, 100, 0, 12);
        run_phase(200, 70, 80, 25, 0, 1);
        run_phase(300, 70, 70, 70, 4, 3);
        run_phase(6, 100, 100, 100, 0, 10);
        mid_reset();
        run_phase(30, 100, 100, 100, 0, 2);
        for (int ph = 0; ph < 10; ph++) begin
            run_phase(120, $urandom_range(100), $urandom_range(100), $urandom_range(100),
                      $urandom_range(6), $urandom_range(1, 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
